id_ex_reg: RTL

//  ID/EX pipeline register of the 5-stage RV32I core. Captures decoded operands and

---
 rtl/id_ex_reg_pkg.sv | 29 ++
 rtl/id_ex_reg_ld_use_detect.sv | 29 ++
 rtl/id_ex_reg.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_pkg.sv
// RV32I shared definitions: opcode encodings, NOP opcode, datapath width, operand-use helpers.
// No logic; constants and pure functions only.
// Used by id_ex_reg, ld_use_detect and ex_ctrl.
package id_ex_reg_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] NOP_OPCODE = OP_IMM;

    // rs1 field is immediate bits for U/J formats
    function automatic logic uses_rs1(input logic [6:0] op);
        return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_REG) || (op == OP_BRANCH) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/id_ex_reg_ld_use_detect.sv
// Load-use hazard detect: EX holds a load whose rd is read by the ID instruction.
// Latency: combinational.
// Backpressure: none; the result is used by the caller to hold ID.
module ld_use_detect
    import id_ex_reg_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            ex_valid,
    input  logic [6:0]      ex_opcode,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            id_valid,
    input  logic [6:0]      id_opcode,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    output logic            load_use_stall
);

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;

    // x0 never carries a real result, so a load to x0 creates no dependency
    assign ex_is_load     = ex_valid && (ex_opcode == OP_LOAD) && (ex_rd != '0);
    assign rs1_hit        = uses_rs1(id_opcode) && (id_rs1 == ex_rd);
    assign rs2_hit        = uses_rs2(id_opcode) && (id_rs2 == ex_rd);
    assign load_use_stall = ex_is_load && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion and EX-redirect flush.
// Latency: 1 cycle ID->EX, full throughput; optional one-entry skid (ID_EX_SKID_EN).
// Backpressure: holds entry while ex_ready=0; id_ready drops on hazard or full stage.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_data1,
    input  logic [XLEN-1:0] id_data2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [6:0]      id_opcode,
    input  logic [2:0]      id_funct3,
    input  logic [6:0]      id_funct7,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_data1,
    output logic [XLEN-1:0] ex_data2,
    output logic [XLEN-1:0] ex_imm,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic            load_use_stall
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] data2;
        logic [XLEN-1:0] imm;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } entry_t;

    function automatic entry_t nop_entry();
        entry_t e;
        e        = '0;
        e.opcode = NOP_OPCODE;
        return e;
    endfunction

    entry_t id_ent;
    entry_t main_q;
    logic   main_vld_q;
    logic   main_load;
    logic   xfer_in;
    logic   hazard_raw;

    assign id_ent = '{pc: id_pc, data1: id_data1, data2: id_data2, imm: id_imm,
                      opcode: id_opcode, funct3: id_funct3, funct7: id_funct7,
                      rs1: id_rs1, rs2: id_rs2, rd: id_rd};

    ld_use_detect #(.RA_W(RA_W)) u_ld_use_detect (
        .ex_valid       (main_vld_q),
        .ex_opcode      (main_q.opcode),
        .ex_rd          (main_q.rd),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .load_use_stall (hazard_raw)
    );

    // the redirect already kills the ID instruction, so a hazard against it is moot
    assign load_use_stall = hazard_raw && !flush;
    assign main_load      = !main_vld_q || ex_ready;

`ifdef ID_EX_SKID_EN
    entry_t skid_q;
    logic   skid_full_q;

    assign id_ready = flush || (!skid_full_q && !load_use_stall);
    assign xfer_in  = id_valid && id_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_vld_q  <= 1'b0;
            main_q      <= nop_entry();
            skid_full_q <= 1'b0;
            skid_q      <= nop_entry();
        end else if (main_load) begin
            // id_ready is low while the skid is full, so no new entry competes here
            if (skid_full_q) begin
                main_vld_q  <= 1'b1;
                main_q      <= skid_q;
                skid_full_q <= 1'b0;
                skid_q      <= nop_entry();
            end else if (xfer_in) begin
                main_vld_q <= 1'b1;
                main_q     <= id_ent;
            end else begin
                main_vld_q <= 1'b0;
                main_q     <= nop_entry();
            end
        end else if (xfer_in) begin
            skid_full_q <= 1'b1;
            skid_q      <= id_ent;
        end
    end
`else
    assign id_ready = flush || ((!main_vld_q || ex_ready) && !load_use_stall);
    assign xfer_in  = id_valid && id_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_vld_q <= 1'b0;
            main_q     <= nop_entry();
        end else if (main_load) begin
            // an empty load slot becomes a NOP bubble so EX sees a clean encoding
            if (xfer_in) begin
                main_vld_q <= 1'b1;
                main_q     <= id_ent;
            end else begin
                main_vld_q <= 1'b0;
                main_q     <= nop_entry();
            end
        end
    end
`endif

    assign ex_valid  = main_vld_q;
    assign ex_pc     = main_q.pc;
    assign ex_data1  = main_q.data1;
    assign ex_data2  = main_q.data2;
    assign ex_imm    = main_q.imm;
    assign ex_opcode = main_q.opcode;
    assign ex_funct3 = main_q.funct3;
    assign ex_funct7 = main_q.funct7;
    assign ex_rs1    = main_q.rs1;
    assign ex_rs2    = main_q.rs2;
    assign ex_rd     = main_q.rd;

endmodule
